// File: rtl/line_mem_initiator_pkg.sv
// Shared definitions for the line memory initiator: default geometry and FSM states.
package line_mem_initiator_pkg;

  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_ADDR_WIDTH     = 16;
  localparam int DEF_BYTE_OFFSET    = 2;
  localparam int DEF_WORDS_PER_LINE = 4;
  localparam int DEF_TIMEOUT        = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WB_ISSUE = 3'd1,
    ST_WB_WAIT  = 3'd2,
    ST_RD_ISSUE = 3'd3,
    ST_RD_WAIT  = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

endpackage

// File: rtl/line_mem_initiator.sv
// Line memory initiator: turns one cache line request (optional victim writeback,
// then fill) into word-by-word RAM transactions, each waiting for ack with a timeout.
module line_mem_initiator
  import line_mem_initiator_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int BYTE_OFFSET    = DEF_BYTE_OFFSET,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int TIMEOUT        = DEF_TIMEOUT,
  localparam int WOFF   = $clog2(WORDS_PER_LINE),
  localparam int LA_W   = ADDR_WIDTH - BYTE_OFFSET - WOFF,
  localparam int LINE_W = DATA_WIDTH * WORDS_PER_LINE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wb,
  input  logic [LA_W-1:0]       req_wb_addr,
  input  logic [LINE_W-1:0]     req_wb_line,
  input  logic [LA_W-1:0]       req_fill_addr,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [LINE_W-1:0]     resp_line,
  output logic                  ram_write_en,
  output logic                  ram_read_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  input  logic                  ram_ack
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [WOFF-1:0]  IDX_LAST = WOFF'(WORDS_PER_LINE - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state;
  logic [WOFF-1:0]   idx;
  logic [CNT_W-1:0]  cnt;
  logic [LA_W-1:0]   wb_addr;
  logic [LA_W-1:0]   fill_addr;
  logic [LINE_W-1:0] wb_line;

  // Main FSM: request latching, word sequencing, ack timeout and line assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      cnt       <= '0;
      wb_addr   <= '0;
      fill_addr <= '0;
      wb_line   <= '0;
      resp_err  <= 1'b0;
      resp_line <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            wb_addr   <= req_wb_addr;
            fill_addr <= req_fill_addr;
            wb_line   <= req_wb_line;
            idx       <= '0;
            cnt       <= '0;
            resp_err  <= 1'b0;
            state     <= req_wb ? ST_WB_ISSUE : ST_RD_ISSUE;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WB_ISSUE: begin
          cnt   <= '0;
          state <= ST_WB_WAIT;
        end
        ST_WB_WAIT: begin
          // An ack arriving in the timeout cycle still completes the word.
          if (ram_ack) begin
            cnt <= '0;
            if (idx != IDX_LAST) begin
              idx   <= idx + WOFF'(1);
              state <= ST_WB_ISSUE;
            end else begin
              idx   <= '0;
              state <= ST_RD_ISSUE;
            end
          end else if (cnt == CNT_LAST) begin
            cnt      <= '0;
            resp_err <= 1'b1;
            state    <= ST_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RD_ISSUE: begin
          cnt   <= '0;
          state <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (ram_ack) begin
            cnt <= '0;
            resp_line[idx*DATA_WIDTH +: DATA_WIDTH] <= ram_rdata;
            if (idx != IDX_LAST) begin
              idx   <= idx + WOFF'(1);
              state <= ST_RD_ISSUE;
            end else begin
              state <= ST_DONE;
            end
          end else if (cnt == CNT_LAST) begin
            cnt      <= '0;
            resp_err <= 1'b1;
            state    <= ST_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Output decode from registered state, index and latched request fields.
  always_comb begin
    req_ready    = (state == ST_IDLE);
    resp_valid   = (state == ST_DONE);
    ram_write_en = (state == ST_WB_ISSUE) && !rst;
    ram_read_en  = (state == ST_RD_ISSUE) && !rst;
    ram_addr     = '0;
    ram_wdata    = '0;
    case (state)
      ST_WB_ISSUE, ST_WB_WAIT: begin
        ram_addr  = {wb_addr, idx, {BYTE_OFFSET{1'b0}}};
        ram_wdata = wb_line[idx*DATA_WIDTH +: DATA_WIDTH];
      end
      ST_RD_ISSUE, ST_RD_WAIT: begin
        ram_addr  = {fill_addr, idx, {BYTE_OFFSET{1'b0}}};
      end
      default: begin
        ram_addr  = '0;
        ram_wdata = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_line_mem_initiator.sv
// Directed bench for line_mem_initiator with a one-cycle-ack behavioural RAM.
module tb_line_mem_initiator;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_wb = 1'b0;
  logic [11:0]  req_wb_addr = 12'h000;
  logic [127:0] req_wb_line = 128'h0;
  logic [11:0]  req_fill_addr = 12'h000;
  logic         resp_valid;
  logic         resp_err;
  logic [127:0] resp_line;
  logic         ram_write_en;
  logic         ram_read_en;
  logic [15:0]  ram_addr;
  logic [31:0]  ram_wdata;
  logic [31:0]  ram_rdata = 32'h0;
  logic         ram_ack;
  logic         ram_ack_r = 1'b0;
  logic         force_ack = 1'b0;
  logic         ram_mute = 1'b0;
  logic         pre_we = 1'b0;
  logic [7:0]   pre_addr = 8'h00;
  logic [31:0]  pre_data = 32'h0;
  logic [31:0]  mem [0:255];

  int checks = 0;
  int errors = 0;
  int resp_count = 0;
  bit viol = 1'b0;
  bit ready_seen;
  logic [48:0] log_q [$];

  localparam logic [127:0] LINE_A = 128'hA0A0_0003_A0A0_0002_A0A0_0001_A0A0_0000;
  localparam logic [127:0] LINE_D = 128'hD0D0_0003_D0D0_0002_D0D0_0001_D0D0_0000;

  line_mem_initiator dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wb(req_wb),
    .req_wb_addr(req_wb_addr), .req_wb_line(req_wb_line), .req_fill_addr(req_fill_addr),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_line(resp_line),
    .ram_write_en(ram_write_en), .ram_read_en(ram_read_en), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ack(ram_ack)
  );

  always #5 clk = ~clk;

  assign ram_ack = ram_ack_r | force_ack;

  // Behavioural RAM: acks one cycle after an enable; mute mode never acks.
  always @(posedge clk) begin
    ram_ack_r <= 1'b0;
    if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (!ram_mute && ram_write_en) begin
      mem[ram_addr[9:2]] <= ram_wdata;
      ram_ack_r <= 1'b1;
    end else if (!ram_mute && ram_read_en) begin
      ram_rdata <= mem[ram_addr[9:2]];
      ram_ack_r <= 1'b1;
    end
  end

  // Transaction log and enable-rule monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (ram_write_en || ram_read_en) log_q.push_back({ram_write_en, ram_addr, ram_wdata});
    if (ram_write_en && ram_read_en) viol = 1'b1;
    if (rst && (ram_write_en || ram_read_en)) viol = 1'b1;
  end

  // Count completed requests.
  always @(negedge clk) begin
    if (resp_valid) resp_count++;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Present a request and return just after the accepting edge.
  task automatic req_start(input logic wb, input logic [11:0] wa, input logic [127:0] wl,
                           input logic [11:0] fa);
    int n;
    @(negedge clk);
    req_wb = wb; req_wb_addr = wa; req_wb_line = wl; req_fill_addr = fa;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 128'(n < 50), 128'(1));
    @(posedge clk);
    #1;
  endtask

  // Wait for resp_valid; lat counts cycles after the accept cycle.
  task automatic wait_resp(input bit drop, output int lat);
    lat = 0;
    ready_seen = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1 && drop) req_valid = 1'b0;
      if (!resp_valid && req_ready) ready_seen = 1'b1;
    end while (!resp_valid && lat < 100);
    chk("resp_timeout", 128'(lat < 100), 128'(1));
  endtask

  initial begin
    int lat;
    int rc;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) poke(8'h14 + 8'(i), 32'hA0A0_0000 | 32'(i));
    @(negedge clk);
    chk("rst_ready", 128'(req_ready), 128'(1));
    chk("rst_valid", 128'(resp_valid), 128'(0));
    chk("rst_err", 128'(resp_err), 128'(0));
    chk("rst_line", resp_line, 128'h0);
    chk("rst_en", 128'({ram_write_en, ram_read_en}), 128'(0));
    chk("rst_addr", 128'(ram_addr), 128'(0));
    chk("rst_wdata", 128'(ram_wdata), 128'(0));
    rst = 1'b0;

    // 1: fill-only
    log_q.delete();
    req_start(1'b0, 12'h000, 128'h0, 12'h005);
    wait_resp(1'b1, lat);
    chk("t1_lat", 128'(lat), 128'(9));
    chk("t1_line", resp_line, LINE_A);
    chk("t1_err", 128'(resp_err), 128'(0));
    chk("t1_busy", 128'(ready_seen), 128'(0));
    chk("t1_nlog", 128'(log_q.size()), 128'(4));
    for (int i = 0; i < 4 && i < log_q.size(); i++)
      chk("t1_rd", 128'(log_q[i][48:32]), 128'({1'b0, 16'h0050 + 16'(4 * i)}));

    // 2: writeback then fill
    log_q.delete();
    req_start(1'b1, 12'h00A, LINE_D, 12'h005);
    wait_resp(1'b1, lat);
    chk("t2_lat", 128'(lat), 128'(17));
    chk("t2_line", resp_line, LINE_A);
    chk("t2_nlog", 128'(log_q.size()), 128'(8));
    for (int i = 0; i < 4 && i + 4 < log_q.size(); i++) begin
      chk("t2_wr", 128'(log_q[i]), 128'({1'b1, 16'h00A0 + 16'(4 * i), 32'hD0D0_0000 | 32'(i)}));
      chk("t2_rd", 128'(log_q[i+4][48:32]), 128'({1'b0, 16'h0050 + 16'(4 * i)}));
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      chk("t2_mem", 128'(mem[8'h28 + 8'(i)]), 128'(32'hD0D0_0000 | 32'(i)));

    // 3: back-to-back with req_valid held high
    req_start(1'b0, 12'h000, 128'h0, 12'h005);
    req_fill_addr = 12'h00A;
    wait_resp(1'b0, lat);
    chk("t3_lat1", 128'(lat), 128'(9));
    chk("t3_busy", 128'(ready_seen), 128'(0));
    chk("t3_line1", resp_line, LINE_A);
    @(negedge clk);
    chk("t3_ready", 128'(req_ready), 128'(1));
    @(posedge clk);
    #1;
    wait_resp(1'b1, lat);
    chk("t3_lat2", 128'(lat), 128'(9));
    chk("t3_line2", resp_line, LINE_D);

    // 4: RAM never acks
    ram_mute = 1'b1;
    req_start(1'b0, 12'h000, 128'h0, 12'h005);
    wait_resp(1'b1, lat);
    chk("t4_lat", 128'(lat), 128'(18));
    chk("t4_err", 128'(resp_err), 128'(1));
    chk("t4_en", 128'({ram_write_en, ram_read_en}), 128'(0));
    ram_mute = 1'b0;
    req_start(1'b0, 12'h000, 128'h0, 12'h005);
    wait_resp(1'b1, lat);
    chk("t4_lat2", 128'(lat), 128'(9));
    chk("t4_err2", 128'(resp_err), 128'(0));
    chk("t4_line2", resp_line, LINE_A);

    // 5: reset during RD_WAIT of word 2
    req_start(1'b0, 12'h000, 128'h0, 12'h00A);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    rc = resp_count;
    rst = 1'b1;
    @(negedge clk);
    chk("t5_en", 128'({ram_write_en, ram_read_en}), 128'(0));
    chk("t5_valid", 128'(resp_valid), 128'(0));
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_ready", 128'(req_ready), 128'(1));
    chk("t5_noresp", 128'(resp_count), 128'(rc));
    req_start(1'b0, 12'h000, 128'h0, 12'h00A);
    wait_resp(1'b1, lat);
    chk("t5_lat", 128'(lat), 128'(9));
    chk("t5_line", resp_line, LINE_D);

    // 6: spurious ack in IDLE
    @(negedge clk);
    rc = resp_count;
    log_q.delete();
    force_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_ready", 128'(req_ready), 128'(1));
      chk("t6_valid", 128'(resp_valid), 128'(0));
    end
    force_ack = 1'b0;
    @(negedge clk);
    chk("t6_ready_after", 128'(req_ready), 128'(1));
    chk("t6_noresp", 128'(resp_count), 128'(rc));
    chk("t6_nolog", 128'(log_q.size()), 128'(0));

    chk("enable_rules", 128'(viol), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
